ace_snoop_responder: RTL and testbench
======================================

# ace_snoop_responder

Cache-side endpoint of the ACE snoop channels. It accepts AC snoop requests from the CCU snoop crossbar and looks up the line state in a tag array. It answers on CR, and when data must be supplied it streams a full cache line on CD, read beat-by-beat from the data array. It updates the line state after the transaction completes. One snoop is handled at a time, and it serves as the snooped-master model for the CCU read/write snoop controllers.

## Interface
- snoop_req_t, default logic: snoop request struct with ac_valid, ac (addr, snoop, prot), cr_ready, cd_ready.
- snoop_resp_t, default logic: snoop response struct with ac_ready, cr_valid, cr_resp (DataTransfer, Error, PassDirty, IsShared, WasUnique), cd_valid, cd (data, last).
- AddrWidth, default 64: AC address width.
- DataWidth, default 64: CD beat width.
- CdBeats, default 4: beats per line. Must be ≥2 and a power of two. BeatW = $clog2(CdBeats).
- Reset is rst_ni, asynchronous, active-low. The clock is clk_i.
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- snoop_req_i  in  snoop_req_t  AC request, CR/CD ready
- snoop_resp_o  out  snoop_resp_t  AC ready, CR response, CD data
- tag_req_o  out  1  tag lookup request, addressed by tag_addr_o
- tag_addr_o  out  AddrWidth  latched AC address
- tag_gnt_i  in  1  lookup accepted
- tag_rvalid_i  in  1  lookup result valid. Arrives ≥1 cycle after the grant.
- tag_state_i  in  3  {valid, unique, dirty}
- data_req_o  out  1  data beat read request
- data_beat_o  out  BeatW  beat index
- data_gnt_i  in  1  read accepted
- data_rvalid_i  in  1  beat data valid
- data_rdata_i  in  DataWidth  beat data
- upd_valid_o  out  1  state write request, using tag_addr_o
- upd_state_o  out  3  new {valid, unique, dirty}
- upd_ready_i  in  1  state write accepted

## Operation
States: IDLE, LOOKUP, TAG_WAIT, CR, RD_REQ, RD_WAIT, CD, UPDATE.

State behaviour:
- **IDLE:** ac_ready=1. On AC handshake, latch ac, go to LOOKUP.
- **LOOKUP:** tag_req_o=1. On tag_gnt_i, go to TAG_WAIT.
- **TAG_WAIT:** on tag_rvalid_i, compute the CR response and new state into registers, then go to CR.
- **CR:** cr_valid=1, cr_resp is registered. On cr_ready:
  - DataTransfer=1: go to RD_REQ with the beat counter at 0.
  - otherwise, state change needed: go to UPDATE.
  - otherwise: go to IDLE.
- **RD_REQ:** data_req_o=1, data_beat_o = counter. On data_gnt_i, go to RD_WAIT.
- **RD_WAIT:** on data_rvalid_i, latch data_rdata_i into the CD register and go to CD.
- **CD:** cd_valid=1, cd.last = (counter == CdBeats-1). On cd_ready:
  - last beat: go to UPDATE if a state change is needed, else IDLE.
  - otherwise: counter+1, go to RD_REQ.
- **UPDATE:** upd_valid_o=1. On upd_ready_i, go to IDLE.

Response rules. V, U, D are the looked-up valid, unique and dirty bits. A miss (V=0) gives CR all-zero and no update.
- ReadOnce: DT=1, IS=1, PD=0, WU=U. State unchanged.
- ReadShared, ReadClean, ReadNotSharedDirty: DT=1, IS=1, PD=D, WU=U. New state {1,0,0}.
- ReadUnique: DT=1, IS=0, PD=D, WU=U. New state {0,0,0}.
- CleanInvalid: DT=D, IS=0, PD=D, WU=U. New state {0,0,0}.
- CleanShared: DT=D, IS=1, PD=D, WU=U. New state {1,U,0}.
- MakeInvalid: DT=0, all other bits 0 except WU=U. New state {0,0,0}.
- Any other snoop code: CR all-zero, Error=0, no update.

Update rule: an update is needed only when the new state differs from the looked-up state.

## Timing
- All outputs are driven from state or registers. There are no combinational paths from AC, CR or CD readies to their valids.
- Reset values: ac_ready=0, cr_valid=0, cr_resp=0, cd_valid=0, cd=0, tag_req_o=0, data_req_o=0, upd_valid_o=0, and every address, state and data output is 0. FSM resets to IDLE.
- ac_ready=1 from the first cycle after reset deasserts.
- Minimum latency with grants high and rvalid one cycle later: AC handshake at cycle t, tag_req at t+1, cr_valid at t+3.
- Per-beat CD cadence is at least 3 cycles (RD_REQ, RD_WAIT, CD).
- Once asserted, a valid holds and its payload stays stable until the handshake.
- A second AC request is not accepted until the FSM returns to IDLE.
- The beat counter wraps only through the reset to 0 on leaving CR. Beats are always issued 0..CdBeats-1, in incrementing order.
- Asynchronous reset mid-transaction returns to IDLE immediately and drops every valid, with no partial update. Recovery of the partner is external.

## Test plan
- Miss: ReadShared to 0x1000 with tag_state=000 -> CR=0x00, no CD, no upd_valid, ac_ready back next cycle.
- ReadShared hit, state 111 (valid, unique, dirty), CdBeats=4 -> DT=1, IS=1, PD=1, WU=1; 4 CD beats carrying data_rdata 0xA0..0xA3 with last on beat 3; then upd_state=100.
- ReadOnce hit, state 100 -> DT=1, IS=1, PD=0, WU=0; 4 beats; no update.
- CleanInvalid hit, state 110 (valid, unique, clean) -> DT=0, WU=1; no CD; upd_state=000.
- Backpressure: cr_ready held 0 for 5 cycles, and cd_ready toggling 0/1 on every beat -> cr_resp and cd.data stay stable while stalled; beat order 0..3 is preserved.
- Reset asserted during CD beat 2 -> all outputs 0 in the same cycle. After release, a new AC request is accepted and completes normally.

Source files
------------

// File: rtl/ace_snoop_responder.sv
// ACE snoop endpoint: takes an AC snoop, looks up the line state, answers on CR,
// streams the line on CD when data must be supplied, then writes back the new state.
package ace_snoop_pkg;
  typedef struct packed {
    logic [63:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } ac_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  // cr_resp bits: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique
  typedef struct packed {
    logic       ac_ready;
    logic       cr_valid;
    logic [4:0] cr_resp;
    logic       cd_valid;
    cd_chan_t   cd;
  } snoop_resp_t;

  localparam logic [3:0] SNP_READ_ONCE     = 4'b0000;
  localparam logic [3:0] SNP_READ_SHARED   = 4'b0001;
  localparam logic [3:0] SNP_READ_CLEAN    = 4'b0010;
  localparam logic [3:0] SNP_READ_NSD      = 4'b0011;
  localparam logic [3:0] SNP_READ_UNIQUE   = 4'b0111;
  localparam logic [3:0] SNP_CLEAN_SHARED  = 4'b1000;
  localparam logic [3:0] SNP_CLEAN_INVALID = 4'b1001;
  localparam logic [3:0] SNP_MAKE_INVALID  = 4'b1101;
endpackage

module ace_snoop_responder
  import ace_snoop_pkg::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned CdBeats   = 4,
  parameter type snoop_req_t  = ace_snoop_pkg::snoop_req_t,
  parameter type snoop_resp_t = ace_snoop_pkg::snoop_resp_t,
  localparam int unsigned BeatW = $clog2(CdBeats)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  snoop_req_t           snoop_req_i,
  output snoop_resp_t          snoop_resp_o,
  output logic                 tag_req_o,
  output logic [AddrWidth-1:0] tag_addr_o,
  input  logic                 tag_gnt_i,
  input  logic                 tag_rvalid_i,
  input  logic [2:0]           tag_state_i,
  output logic                 data_req_o,
  output logic [BeatW-1:0]     data_beat_o,
  input  logic                 data_gnt_i,
  input  logic                 data_rvalid_i,
  input  logic [DataWidth-1:0] data_rdata_i,
  output logic                 upd_valid_o,
  output logic [2:0]           upd_state_o,
  input  logic                 upd_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_TAG_WAIT, S_CR, S_RD_REQ, S_RD_WAIT, S_CD, S_UPDATE
  } state_e;

  typedef struct packed {
    logic [4:0] cr;
    logic [2:0] nst;
  } rule_t;

  state_e               state_q, state_d;
  logic                 ac_ready_q;
  logic [AddrWidth-1:0] addr_q;
  logic [3:0]           snoop_q;
  logic [4:0]           cr_q;
  logic [2:0]           nst_q;
  logic                 upd_need_q;
  logic [BeatW-1:0]     beat_q;
  logic [DataWidth-1:0] cd_data_q;
  logic                 last_beat;
  rule_t                rule;

  function automatic rule_t snoop_rule(input logic [3:0] snoop, input logic [2:0] st);
    rule_t r;
    logic  u, d;
    u = st[1];
    d = st[0];
    r.cr  = '0;
    r.nst = st;
    if (st[2]) begin
      unique case (snoop)
        SNP_READ_ONCE:                                 r.cr = {u, 1'b1, 1'b0, 1'b0, 1'b1};
        SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD: begin
          r.cr  = {u, 1'b1, d, 1'b0, 1'b1};
          r.nst = 3'b100;
        end
        SNP_READ_UNIQUE: begin
          r.cr  = {u, 1'b0, d, 1'b0, 1'b1};
          r.nst = 3'b000;
        end
        SNP_CLEAN_INVALID: begin
          r.cr  = {u, 1'b0, d, 1'b0, d};
          r.nst = 3'b000;
        end
        SNP_CLEAN_SHARED: begin
          r.cr  = {u, 1'b1, d, 1'b0, d};
          r.nst = {1'b1, u, 1'b0};
        end
        SNP_MAKE_INVALID: begin
          r.cr  = {u, 4'b0000};
          r.nst = 3'b000;
        end
        default: ;
      endcase
    end
    return r;
  endfunction

  assign rule      = snoop_rule(snoop_q, tag_state_i);
  assign last_beat = (beat_q == BeatW'(CdBeats - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      ac_ready_q <= 1'b0;
      addr_q     <= '0;
      snoop_q    <= '0;
      cr_q       <= '0;
      nst_q      <= '0;
      upd_need_q <= 1'b0;
      beat_q     <= '0;
      cd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ac_ready_q <= (state_d == S_IDLE);
      if (state_q == S_IDLE && snoop_req_i.ac_valid && ac_ready_q) begin
        addr_q  <= snoop_req_i.ac.addr;
        snoop_q <= snoop_req_i.ac.snoop;
      end
      if (state_q == S_TAG_WAIT && tag_rvalid_i) begin
        cr_q       <= rule.cr;
        nst_q      <= rule.nst;
        upd_need_q <= (rule.nst != tag_state_i);
      end
      if (state_q == S_CR && snoop_req_i.cr_ready) beat_q <= '0;
      if (state_q == S_CD && snoop_req_i.cd_ready && !last_beat) beat_q <= beat_q + BeatW'(1);
      if (state_q == S_RD_WAIT && data_rvalid_i) cd_data_q <= data_rdata_i;
    end
  end

  // Every output is decoded from the state register or a held register
  always_comb begin
    state_d      = state_q;
    snoop_resp_o = '0;
    snoop_resp_o.ac_ready = ac_ready_q;
    snoop_resp_o.cr_resp  = cr_q;
    snoop_resp_o.cd.data  = cd_data_q;
    tag_req_o    = 1'b0;
    tag_addr_o   = addr_q;
    data_req_o   = 1'b0;
    data_beat_o  = beat_q;
    upd_valid_o  = 1'b0;
    upd_state_o  = nst_q;
    unique case (state_q)
      S_IDLE:     if (snoop_req_i.ac_valid && ac_ready_q) state_d = S_LOOKUP;
      S_LOOKUP: begin
        tag_req_o = 1'b1;
        if (tag_gnt_i) state_d = S_TAG_WAIT;
      end
      S_TAG_WAIT: if (tag_rvalid_i) state_d = S_CR;
      S_CR: begin
        snoop_resp_o.cr_valid = 1'b1;
        if (snoop_req_i.cr_ready) begin
          if (cr_q[0])         state_d = S_RD_REQ;
          else if (upd_need_q) state_d = S_UPDATE;
          else                 state_d = S_IDLE;
        end
      end
      S_RD_REQ: begin
        data_req_o = 1'b1;
        if (data_gnt_i) state_d = S_RD_WAIT;
      end
      S_RD_WAIT:  if (data_rvalid_i) state_d = S_CD;
      S_CD: begin
        snoop_resp_o.cd_valid = 1'b1;
        snoop_resp_o.cd.last  = last_beat;
        if (snoop_req_i.cd_ready) begin
          if (!last_beat)      state_d = S_RD_REQ;
          else if (upd_need_q) state_d = S_UPDATE;
          else                 state_d = S_IDLE;
        end
      end
      S_UPDATE: begin
        upd_valid_o = 1'b1;
        if (upd_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Scoreboard bench for ace_snoop_responder: tag/data array responders, ready
// backpressure driver, and a negedge monitor popping expected CR/CD/update values.
module tb_ace_snoop_responder;
  import ace_snoop_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  snoop_req_t  req;
  snoop_resp_t resp;
  logic        tag_req, tag_gnt, tag_rvalid;
  logic [63:0] tag_addr;
  logic [2:0]  tag_state;
  logic        data_req, data_gnt, data_rvalid;
  logic [1:0]  data_beat;
  logic [63:0] data_rdata;
  logic        upd_valid, upd_ready;
  logic [2:0]  upd_state;

  logic        ac_valid = 1'b0;
  logic [63:0] ac_addr = '0;
  logic [3:0]  ac_snoop = '0;
  logic        cr_rdy = 1'b1, cd_rdy = 1'b1;
  logic [2:0]  cur_tag = '0;
  logic [63:0] data_base = '0;
  bit          bp_mode = 1'b0;
  int          cr_stall = 0;
  bit          cd_stalled = 1'b0;
  bit          tag_pend = 1'b0, data_pend = 1'b0;
  logic [1:0]  pend_beat = '0;
  int          cyc = 0;
  int          total = 0, bad = 0;

  logic [4:0]  cr_exp_q[$];
  logic [64:0] cd_exp_q[$];
  logic [2:0]  upd_exp_q[$];

  bit          cr_hold = 1'b0, cd_hold = 1'b0;
  logic [4:0]  cr_held;
  logic [64:0] cd_held;

  assign tag_gnt   = 1'b1;
  assign data_gnt  = 1'b1;
  assign upd_ready = 1'b1;
  assign tag_state = cur_tag;

  always_comb begin
    req          = '0;
    req.ac_valid = ac_valid;
    req.ac.addr  = ac_addr;
    req.ac.snoop = ac_snoop;
    req.cr_ready = cr_rdy;
    req.cd_ready = cd_rdy;
  end

  ace_snoop_responder #(.AddrWidth(64), .DataWidth(64), .CdBeats(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .snoop_req_i(req), .snoop_resp_o(resp),
    .tag_req_o(tag_req), .tag_addr_o(tag_addr), .tag_gnt_i(tag_gnt),
    .tag_rvalid_i(tag_rvalid), .tag_state_i(tag_state),
    .data_req_o(data_req), .data_beat_o(data_beat), .data_gnt_i(data_gnt),
    .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata),
    .upd_valid_o(upd_valid), .upd_state_o(upd_state), .upd_ready_i(upd_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Array responders: result/beat data one cycle after an accepted request
  always @(negedge clk) begin
    if (!rst_ni) begin
      tag_pend = 1'b0; data_pend = 1'b0; tag_rvalid = 1'b0; data_rvalid = 1'b0;
    end else begin
      tag_rvalid  = tag_pend;
      tag_pend    = tag_req && tag_gnt;
      data_rvalid = data_pend;
      if (data_pend) data_rdata = data_base + {62'd0, pend_beat};
      data_pend   = data_req && data_gnt;
      pend_beat   = data_beat;
    end
  end

  initial begin
    data_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        if (resp.cr_valid && cr_stall < 5) begin cr_rdy = 1'b0; cr_stall++; end
        else cr_rdy = 1'b1;
        if (resp.cd_valid && !cd_stalled) begin cd_rdy = 1'b0; cd_stalled = 1'b1; end
        else begin cd_rdy = 1'b1; if (!resp.cd_valid) cd_stalled = 1'b0; end
      end else begin
        cr_rdy = 1'b1; cd_rdy = 1'b1;
      end
    end
  end

  // Monitor: a valid&ready seen at negedge completes on the next posedge
  always @(negedge clk) begin
    if (!rst_ni) begin
      cr_hold = 1'b0; cd_hold = 1'b0;
    end else begin
      if (cr_hold) chk("cr_stable", {resp.cr_valid, resp.cr_resp}, {1'b1, cr_held});
      if (cd_hold) chk("cd_stable", {resp.cd_valid, resp.cd}, {1'b1, cd_held});
      cr_hold = resp.cr_valid && !cr_rdy;
      cr_held = resp.cr_resp;
      cd_hold = resp.cd_valid && !cd_rdy;
      cd_held = resp.cd;
      if (resp.cr_valid && cr_rdy) begin
        if (cr_exp_q.size() == 0) chk("cr_unexpected", resp.cr_valid, 1'b0);
        else chk("cr_resp", resp.cr_resp, cr_exp_q.pop_front());
      end
      if (resp.cd_valid && cd_rdy) begin
        if (cd_exp_q.size() == 0) chk("cd_unexpected", resp.cd_valid, 1'b0);
        else chk("cd_beat", resp.cd, cd_exp_q.pop_front());
      end
      if (upd_valid && upd_ready) begin
        if (upd_exp_q.size() == 0) chk("upd_unexpected", upd_valid, 1'b0);
        else chk("upd_state", upd_state, upd_exp_q.pop_front());
      end
    end
  end

  task automatic push_exp(input logic [4:0] cr, input bit has_data, input logic [63:0] base,
                          input bit has_upd, input logic [2:0] nst);
    cr_exp_q.push_back(cr);
    if (has_data)
      for (int i = 0; i < 4; i++) cd_exp_q.push_back({base + 64'(i), i == 3});
    if (has_upd) upd_exp_q.push_back(nst);
  endtask

  task automatic issue_ac(input logic [63:0] addr, input logic [3:0] code, output int hs);
    bit ok = 1'b0;
    hs = 0;
    @(posedge clk); #1;
    ac_valid = 1'b1; ac_addr = addr; ac_snoop = code;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp.ac_ready) begin ok = 1'b1; hs = cyc; break; end
    end
    chk("ac_accept", ok, 1'b1);
    @(posedge clk); #1;
    ac_valid = 1'b0;
    @(negedge clk);
    chk("ac_busy", resp.ac_ready, 1'b0);
    chk("tag_addr", tag_addr, addr);
    chk("tag_req_lat", tag_req, 1'b1);
  endtask

  task automatic run_snoop(input logic [63:0] addr, input logic [3:0] code, input logic [2:0] st,
                           input logic [4:0] cr, input bit has_data, input logic [63:0] base,
                           input bit has_upd, input logic [2:0] nst);
    int hs;
    bit ok = 1'b0;
    cur_tag = st; data_base = base; cr_stall = 0;
    push_exp(cr, has_data, base, has_upd, nst);
    issue_ac(addr, code, hs);
    for (int i = 0; i < 20; i++) begin
      if (resp.cr_valid) break;
      @(negedge clk);
    end
    chk("cr_latency", cyc - hs, 3);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cr_exp_q.size() == 0 && cd_exp_q.size() == 0 && upd_exp_q.size() == 0 && resp.ac_ready) begin
        ok = 1'b1; break;
      end
    end
    chk("txn_done", ok, 1'b1);
  endtask

  initial begin
    int hs;
    bit ok;
    #1;
    chk("rst_resp", resp, '0);
    chk("rst_side", {tag_req, tag_addr, data_req, data_beat, upd_valid, upd_state}, '0);
    #22 rst_ni = 1'b1;
    @(posedge clk); #1;
    chk("ac_ready_after_rst", resp.ac_ready, 1'b1);

    // Miss, then hits with various snoop codes and line states
    run_snoop(64'h1000, SNP_READ_SHARED,   3'b000, 5'h00, 0, 64'h0,  0, 3'b000);
    run_snoop(64'h2000, SNP_READ_SHARED,   3'b111, 5'h1D, 1, 64'hA0, 1, 3'b100);
    run_snoop(64'h2040, SNP_READ_ONCE,     3'b100, 5'h09, 1, 64'h50, 0, 3'b000);
    run_snoop(64'h2080, SNP_CLEAN_INVALID, 3'b110, 5'h10, 0, 64'h0,  1, 3'b000);
    run_snoop(64'h20C0, SNP_READ_UNIQUE,   3'b101, 5'h05, 1, 64'h70, 1, 3'b000);
    run_snoop(64'h2100, SNP_CLEAN_SHARED,  3'b111, 5'h1D, 1, 64'h80, 1, 3'b110);
    run_snoop(64'h2140, SNP_MAKE_INVALID,  3'b111, 5'h10, 0, 64'h0,  1, 3'b000);
    run_snoop(64'h2180, 4'b0100,           3'b111, 5'h00, 0, 64'h0,  0, 3'b000);

    // Backpressure on CR and every CD beat
    bp_mode = 1'b1;
    run_snoop(64'h3000, SNP_READ_SHARED, 3'b101, 5'h0D, 1, 64'hB0, 1, 3'b100);
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);

    // Asynchronous reset in the middle of CD beat 2
    cur_tag = 3'b111; data_base = 64'hC0;
    push_exp(5'h1D, 1, 64'hC0, 1, 3'b100);
    issue_ac(64'h4000, SNP_READ_SHARED, hs);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (resp.cd_valid && data_beat == 2'd2) begin ok = 1'b1; break; end
    end
    chk("reach_beat2", ok, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_resp", resp, '0);
    chk("midrst_side", {tag_req, tag_addr, data_req, data_beat, upd_valid, upd_state}, '0);
    cr_exp_q.delete(); cd_exp_q.delete(); upd_exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_ni = 1'b1;
    run_snoop(64'h5000, SNP_READ_ONCE, 3'b110, 5'h19, 1, 64'hD0, 0, 3'b000);
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
